piradspi_cmd_arbiter: RTL and testbench
=======================================

Name: piradspi_cmd_arbiter

Overview:
Round-robin arbiter that shares one SPI command stream among NREQ requesters, e.g. several register-bank or DMA front-ends feeding one command FIFO and engine.
- Grants one requester at a time and passes its commands through combinationally.
- Supports a lock so a requester keeps ownership across a multi-command SPI transaction.
- Enforces a burst limit and an idle-lock timeout so no requester starves the others.

Parameters:
NREQ, 4, number of requesters (2..16)
CMD_WIDTH, 64, width of flattened command word (packed command struct padded to bytes)
MAX_BURST, 8, max consecutive commands per grant under lock; 0 = unlimited
LOCK_TIMEOUT, 16, consecutive cycles a locked owner may hold the grant with req_valid low before forced release; 0 = never

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester command valid
req_ready  out  NREQ  per-requester command ready
req_cmd  in  NREQ*CMD_WIDTH  per-requester command; requester i occupies bits [i*CMD_WIDTH +: CMD_WIDTH]
req_lock  in  NREQ  per-requester request to retain grant after the current command
cmd_valid  out  1  arbitrated command valid (to cmd FIFO)
cmd_ready  in  1  downstream ready
cmd  out  CMD_WIDTH  arbitrated command
cmd_src  out  max(1,$clog2(NREQ))  index of current owner
grant  out  NREQ  one-hot owner; all zero when idle
busy  out  1  high while state == OWN

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE, grant = 0, cmd_src = 0, busy = 0, cmd_valid = 0, req_ready = 0.
  - last_owner = NREQ-1, so requester 0 has first priority.
  - burst_cnt = 0, idle_cnt = 0.
- States: IDLE, OWN.
- IDLE:
  - If any req_valid is high, select the first set bit searching last_owner+1, last_owner+2, ... modulo NREQ.
  - Register grant/cmd_src, clear burst_cnt and idle_cnt, go to OWN.
  - No transfer happens in IDLE.
- OWN, combinational outputs:
  - cmd_valid = req_valid[owner], cmd = req_cmd[owner].
  - req_ready[owner] = cmd_ready; all other req_ready = 0.
- Transfer = cmd_valid & cmd_ready. On transfer: burst_cnt+1, idle_cnt cleared.
  - Stay in OWN if req_lock[owner] is high in the transfer cycle and (MAX_BURST == 0 or burst_cnt+1 < MAX_BURST).
  - Otherwise release: last_owner = owner, grant = 0, go to IDLE.
- OWN, no transfer:
  - req_valid[owner] = 0 and req_lock[owner] = 0 -> release (grant obtained without sending, or lock dropped).
  - req_valid[owner] = 0 and req_lock[owner] = 1 -> idle_cnt+1. Release when idle_cnt+1 == LOCK_TIMEOUT (LOCK_TIMEOUT != 0).
  - req_valid[owner] = 1 and cmd_ready = 0 -> hold. Never release or switch while cmd_valid is high without a transfer (AXI-stream stability).
- Latency:
  - req_valid rising in IDLE at cycle t -> grant and cmd_valid at t+1.
  - Exactly one bubble cycle (IDLE) between successive owners; same owner under lock has back-to-back transfers.
- Fairness: the just-released owner has lowest priority in the next arbitration. A sole requester is re-granted after one bubble.
- Counter widths:
  - burst_cnt sized for MAX_BURST and saturates when MAX_BURST == 0.
  - idle_cnt sized for LOCK_TIMEOUT.
- Assertions:
  - grant is one-hot or zero.
  - At most one req_ready is high.
  - cmd stable while cmd_valid & !cmd_ready.
- aresetn asserted mid-command drops cmd_valid immediately; the downstream FIFO is reset on the same aresetn.

Test Plan:
- After reset, all 4 req_valid high with lock=0 and cmd_ready=1 -> grants 0,1,2,3,0 in order, one transfer each, one IDLE cycle between; cmd_src matches; cmd equals the granted req_cmd.
- Requester 2 locked, 10 commands back-to-back, MAX_BURST=8 -> 8 consecutive transfers, release; another waiting requester is served next; 2 regains grant for the remaining 2.
- Owner 1 locked, req_valid low 16 cycles, LOCK_TIMEOUT=16 -> release on 16th idle cycle; waiting requester 3 granted the next cycle.
- cmd_ready held low 5 cycles with owner 0 valid and requester 1 also valid -> cmd and cmd_valid stable, grant stays 0, no release; transfer on ready high, then grant moves to 1.
- Single requester 3, lock=0, 3 commands -> transfers at t+1, t+3, t+5 (bubble between); grant/busy toggle accordingly.
- aresetn pulsed while owner 2 is mid-burst -> outputs zero immediately; after release, requester 0 has priority.

Source files
------------

// File: rtl/piradspi_cmd_arbiter.sv
// Round-robin arbiter that multiplexes NREQ SPI command streams onto one
// command channel, with owner lock, burst limit and idle-lock timeout.
module piradspi_cmd_arbiter #(
    parameter int NREQ         = 4,
    parameter int CMD_WIDTH    = 64,
    parameter int MAX_BURST    = 8,
    parameter int LOCK_TIMEOUT = 16,
    localparam int SW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*CMD_WIDTH-1:0] req_cmd,
    input  logic [NREQ-1:0]           req_lock,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [CMD_WIDTH-1:0]      cmd,
    output logic [SW-1:0]             cmd_src,
    output logic [NREQ-1:0]           grant,
    output logic                      busy
);

    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int IW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   owner_q, owner_d;
    logic [SW-1:0]   last_q, last_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

    logic            pick_found;
    logic [SW-1:0]   pick_idx;
    logic            own_valid, own_lock, xfer;
    logic            burst_room, idle_hit, release_own;

    // Search starts just past the previous owner so it ends up lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [SW-1:0] cand;
            cand = SW'((int'(last_q) + k) % NREQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign busy       = (state_q == OWN);
    assign cmd_src    = owner_q;
    assign own_valid  = req_valid[owner_q];
    assign own_lock   = req_lock[owner_q];
    assign cmd        = req_cmd[owner_q*CMD_WIDTH +: CMD_WIDTH];
    assign xfer       = cmd_valid & cmd_ready;
    assign burst_room = (MAX_BURST == 0) || (int'(burst_cnt_q) + 1 < MAX_BURST);
    assign idle_hit   = (LOCK_TIMEOUT != 0) && (int'(idle_cnt_q) + 1 == LOCK_TIMEOUT);

    always_comb begin
        grant     = '0;
        req_ready = '0;
        cmd_valid = 1'b0;
        if (busy) begin
            grant[owner_q]     = 1'b1;
            req_ready[owner_q] = cmd_ready;
            cmd_valid          = own_valid;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        release_own = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = OWN;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            OWN: begin
                if (xfer) begin
                    idle_cnt_d  = '0;
                    burst_cnt_d = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + 1'b1;
                    release_own = !(own_lock && burst_room);
                end else if (!own_valid) begin
                    if (!own_lock) begin
                        release_own = 1'b1;
                    end else begin
                        idle_cnt_d  = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 1'b1;
                        release_own = idle_hit;
                    end
                end
                // valid without ready falls through: hold for stream stability
                if (release_own) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= SW'(NREQ - 1);
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot0: assert property (@(posedge aclk) disable iff (!aresetn)
        $onehot0(grant));
    a_ready_onehot0: assert property (@(posedge aclk) disable iff (!aresetn)
        $onehot0(req_ready));
    a_cmd_stable: assert property (@(posedge aclk) disable iff (!aresetn)
        (cmd_valid && !cmd_ready) |=> $stable(cmd));
`endif

endmodule

// File: tb/tb_piradspi_cmd_arbiter.sv
// Randomized bench for piradspi_cmd_arbiter against a transaction-level
// ownership model (owner / last owner / burst and idle counts as integers).
module tb_piradspi_cmd_arbiter;
    localparam int NREQ = 4;
    localparam int CW   = 64;
    localparam int MB   = 8;
    localparam int LT   = 16;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*CW-1:0]   req_cmd;
    logic [NREQ-1:0]      req_lock;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CW-1:0]        cmd;
    logic [1:0]           cmd_src;
    logic [NREQ-1:0]      grant;
    logic                 busy;

    piradspi_cmd_arbiter #(.NREQ(NREQ), .CMD_WIDTH(CW), .MAX_BURST(MB), .LOCK_TIMEOUT(LT)) dut (
        .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_lock(req_lock), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_src(cmd_src), .grant(grant), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // requester side
    bit          has  [NREQ];
    logic [CW-1:0] cmdv [NREQ];
    bit          lk   [NREQ];
    int          p_arr, p_rdy, lock_mode;

    // reference model: -1 means nobody owns the channel
    int m_own, m_last, m_bc, m_ic;

    task automatic model_reset();
        m_own  = -1;
        m_last = NREQ - 1;
        m_bc   = 0;
        m_ic   = 0;
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_busy"},  64'(busy), 64'(0));
        chk({pfx, "_grant"}, 64'(grant), 64'(0));
        chk({pfx, "_cvalid"}, 64'(cmd_valid), 64'(0));
        chk({pfx, "_rready"}, 64'(req_ready), 64'(0));
    endtask

    // Drive one cycle's inputs, check outputs, then advance the model.
    task automatic cycle_body();
        bit rdy;
        for (int i = 0; i < NREQ; i++) begin
            if (!has[i] && $urandom_range(99) < p_arr) begin
                has[i]  = 1'b1;
                cmdv[i] = {$urandom, $urandom};
            end
            case (lock_mode)
                0: lk[i] = 1'b0;
                1: lk[i] = 1'b1;
                default: if ($urandom_range(39) == 0) lk[i] = !lk[i];
            endcase
            req_valid[i]           = has[i];
            req_lock[i]            = lk[i];
            req_cmd[i*CW +: CW]    = cmdv[i];
        end
        rdy       = ($urandom_range(99) < p_rdy);
        cmd_ready = rdy;
        #1;
        if (m_own < 0) begin
            chk_idle_outputs("idle");
        end else begin
            chk("own_busy",   64'(busy), 64'(1));
            chk("own_grant",  64'(grant), 64'(1 << m_own));
            chk("own_src",    64'(cmd_src), 64'(m_own));
            chk("own_cvalid", 64'(cmd_valid), 64'(has[m_own]));
            chk("own_rready", 64'(req_ready), rdy ? 64'(1 << m_own) : 64'(0));
            chk("own_cmd",    cmd, cmdv[m_own]);
        end
        if (m_own < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_last + k) % NREQ;
                if (m_own < 0 && has[j]) begin
                    m_own = j;
                    m_bc  = 0;
                    m_ic  = 0;
                end
            end
        end else begin
            int o;
            bit rel;
            o   = m_own;
            rel = 1'b0;
            if (has[o] && rdy) begin
                has[o] = 1'b0;
                m_bc++;
                m_ic = 0;
                rel = !(lk[o] && (MB == 0 || m_bc < MB));
            end else if (!has[o]) begin
                if (!lk[o]) rel = 1'b1;
                else begin
                    m_ic++;
                    if (LT != 0 && m_ic == LT) rel = 1'b1;
                end
            end
            if (rel) begin
                m_last = o;
                m_own  = -1;
            end
        end
    endtask

    task automatic step();
        @(negedge aclk);
        cycle_body();
    endtask

    task automatic reset_pulse();
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk_idle_outputs("rst");
        chk("rst_src", 64'(cmd_src), 64'(0));
        model_reset();
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        cycle_body();
    endtask

    task automatic run_phase(input int pa, input int pr, input int lm, input int n, input int rst_at);
        p_arr     = pa;
        p_rdy     = pr;
        lock_mode = lm;
        for (int c = 0; c < n; c++) begin
            if (c == rst_at) reset_pulse();
            else step();
        end
    endtask

    initial begin
        aresetn   = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        req_cmd   = '0;
        cmd_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            has[i]  = 1'b0;
            lk[i]   = 1'b0;
            cmdv[i] = '0;
        end
        model_reset();
        #2;
        chk_idle_outputs("por");
        chk("por_src", 64'(cmd_src), 64'(0));
        p_arr = 100; p_rdy = 100; lock_mode = 0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        cycle_body();
        // plain round robin, everybody always requesting
        run_phase(100, 100, 0, 200, -1);
        // locked back-to-back bursts hit the burst limit; reset mid-burst
        run_phase(100, 100, 1, 300, 150);
        // locked owners with sparse traffic hit the idle timeout
        run_phase(4, 100, 1, 400, -1);
        // mixed lock toggling with downstream backpressure
        run_phase(60, 60, 2, 600, 333);
        run_phase(30, 50, 2, 400, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
